// File: rtl/bcd_ascii_streamer.sv
// Packed-BCD word to ASCII byte streamer: validates nibbles, then emits MSD first plus optional terminator.
// Optional LEAD_ZERO_BLANK_EN: skip leading zero digits (the least significant digit is always sent).
module bcd_ascii_streamer #(
  parameter int         DIGITS      = 4,
  parameter bit         APPEND_TERM = 1'b1,
  parameter logic [7:0] TERM_CHAR   = 8'h0D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_char,
  output logic                out_last,
  output logic                err,
  output logic                busy
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic [2:0]   idx_q, idx_d;
  logic         out_valid_q, out_valid_d;
  logic [7:0]   out_char_q, out_char_d;
  logic         out_last_q, out_last_d;
  logic         err_q, err_d;

  function automatic logic [3:0] nib(input logic [W-1:0] w, input logic [2:0] i);
    logic [W-1:0] sh;
    sh = w >> {i, 2'b00};
    return sh[3:0];
  endfunction

  logic       all_ok;
  logic [2:0] first_idx;

  always_comb begin
    all_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (nib(in_bcd, 3'(i)) > 4'd9) all_ok = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
    // Highest non-zero digit wins; an all-zero word falls back to digit 0.
    first_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++)
      if (nib(in_bcd, 3'(i)) != 4'd0) first_idx = 3'(i);
`else
    first_idx = 3'(DIGITS - 1);
`endif
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!all_ok) begin
            err_d = 1'b1;
          end else begin
            word_d      = in_bcd;
            idx_d       = first_idx;
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_char_d  = 8'h30 | {4'h0, nib(in_bcd, first_idx)};
            out_last_d  = !APPEND_TERM && (first_idx == 3'd0);
          end
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q != 3'd0) begin
            idx_d      = idx_q - 3'd1;
            out_char_d = 8'h30 | {4'h0, nib(word_q, idx_q - 3'd1)};
            out_last_d = !APPEND_TERM && (idx_q == 3'd1);
          end else if (APPEND_TERM) begin
            state_d    = TERM;
            out_char_d = TERM_CHAR;
            out_last_d = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_char_d  = 8'h00;
            out_last_d  = 1'b0;
          end
        end
      end
      TERM: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_char_d  = 8'h00;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
endmodule
